norm_check_seq: RTL and testbench
=================================

Name: norm_check_seq

Overview:
Downstream sequencer for the signing-path validity checks. It drives the norm-check engine through the three checks in fixed order: z (L polys), r0 (K polys), ct0 (K polys). It captures each per-vector invalid flag on the engine's done pulse and honours the engine's ready handshake. It then reports one sign-reject verdict with a per-check cause vector to the high-level controller (HLC).

Parameters:
TIMEOUT_CYCLES, 4096, max cycles allowed in WAIT_DONE per check before declaring an engine error.
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
zeroize  input  1  synchronous clear, same effect as reset
start  input  1  one-cycle pulse from HLC; starts a 3-check sequence
z_base_addr  input  ABR_MEM_ADDR_WIDTH  memory base of z vector
r0_base_addr  input  ABR_MEM_ADDR_WIDTH  memory base of r0 vector
ct0_base_addr  input  ABR_MEM_ADDR_WIDTH  memory base of ct0 vector
norm_check_enable  output  1  one-cycle launch pulse to the engine
mode  output  chk_norm_mode_t  check selector to the engine
mem_base_addr  output  ABR_MEM_ADDR_WIDTH  base address to the engine
nc_invalid  input  1  engine accumulated invalid flag
nc_done  input  1  engine done pulse
nc_ready  input  1  engine ready pulse, one cycle after done
busy  output  1  sequence in progress
seq_done  output  1  one-cycle pulse when the verdict is valid
reject  output  1  verdict; 1 = signature attempt must be rejected
reject_cause  output  3  bit0 z, bit1 r0, bit2 ct0 invalid
engine_err  output  1  watchdog expired during the sequence

Behaviour:
- Reset and zeroize values: all outputs 0; state IDLE; check index idx=0; mode = z encoding; mem_base_addr=0. Zeroize takes effect in any state and aborts the sequence with no seq_done.
- The FSM has five states: IDLE, ISSUE, WAIT_DONE, WAIT_READY, FINISH.
- IDLE:
  - start=1 clears reject_cause and engine_err, sets idx=0, then moves to ISSUE.
  - start while busy=1 is ignored.
- ISSUE (1 cycle):
  - norm_check_enable=1.
  - mode and mem_base_addr are registered from idx: 0 selects z, 1 selects r0, 2 selects ct0, each with its own base address. They were loaded on the entry edge, so they are valid in the same cycle as the enable.
  - Watchdog is cleared. Next state is WAIT_DONE.
- mode and mem_base_addr hold stable from ISSUE until leaving WAIT_READY, because the engine uses mode combinationally during the whole check.
- WAIT_DONE:
  - The watchdog increments every cycle.
  - On nc_done=1, reject_cause[idx] <= nc_invalid and the FSM moves to WAIT_READY.
  - If the watchdog reaches TIMEOUT_CYCLES with no done, engine_err <= 1 and the FSM moves to FINISH.
  - nc_done and the timeout in the same cycle: done wins.
- WAIT_READY:
  - On nc_ready=1: if idx==2, go to FINISH. Otherwise idx <= idx+1 and go to ISSUE.
  - nc_ready arriving in the same cycle as nc_done (out of protocol) is ignored, because the FSM is not yet in WAIT_READY.
- FINISH (1 cycle):
  - seq_done=1.
  - reject <= (|reject_cause) | engine_err, registered so it is valid in the seq_done cycle.
  - Next state is IDLE.
- reject, reject_cause and engine_err hold until the next accepted start or zeroize.
- busy=1 in every state except IDLE.
- Latency with an engine that takes D cycles from enable to done, and ready one cycle after done: per check 1 (ISSUE) + D + 1 (WAIT_READY); total = 3(D+2) + 1 (FINISH) cycles from start to seq_done.
- nc_done or nc_ready outside the matching wait state is ignored and never corrupts reject_cause.

Optional Feature:
NORM_CHECK_SEQ_EARLY_ABORT_EN.
- Defined: in WAIT_READY, if reject_cause[idx]=1, go directly to FINISH after nc_ready and skip the remaining checks. Later cause bits stay 0.
- Undefined: all three checks always run, whatever the earlier results, so timing is constant and independent of data.

Test Plan:
1. All valid: start; engine returns invalid=0 three times with D=20 -> three enable pulses with modes z, r0, ct0 and the three base addresses; seq_done at cycle 67 after start; reject=0; cause=3'b000.
2. r0 invalid: nc_invalid=1 only on the second check -> reject=1, cause=3'b010. Macro undefined: 3 enables. Macro defined: 2 enables, seq_done 22 cycles earlier.
3. Timeout: TIMEOUT_CYCLES=16, engine never asserts done on the ct0 check -> engine_err=1, reject=1, cause=3'b000, seq_done 16 cycles after entering WAIT_DONE.
4. Zeroize in WAIT_DONE of the z check -> next cycle busy=0, all outputs 0, no seq_done pulse; a subsequent start runs cleanly.
5. start pulsed while busy, plus a spurious nc_done in ISSUE -> sequence unaffected; still exactly 3 enables and the correct cause.
6. Back-to-back: a new start in the cycle after seq_done -> previous cause cleared and a new sequence completes with independent results.

Source files
------------

// File: rtl/norm_check_seq.sv
// norm_check_seq
//   Sequencer for the signing-path validity checks. It runs the norm-check
//   engine over z (mode 0), r0 (mode 1) and ct0 (mode 2) in that fixed order.
//   It latches each invalid flag on the engine's done pulse and waits for the
//   engine's ready pulse before issuing the next check. It then reports one
//   reject verdict with a per-check cause vector.
//
//   Ports
//     clk, reset, zeroize         clock, sync active-high reset, sync clear
//     start                       one-cycle sequence start (ignored while busy)
//     z/r0/ct0_base_addr          memory base address of each vector
//     norm_check_enable           one-cycle engine launch pulse
//     mode, mem_base_addr         check selector and base address to the engine
//     nc_invalid/nc_done/nc_ready engine result flag and handshake pulses
//     busy, seq_done              sequence in progress, verdict-valid pulse
//     reject, reject_cause        verdict and cause (bit0 z, bit1 r0, bit2 ct0)
//     engine_err                  watchdog expired while waiting for done
//
//   Build option: NORM_CHECK_SEQ_EARLY_ABORT_EN stops the sequence after the
//   first invalid check. Without it, all three checks always run so that
//   timing does not depend on the data.
module norm_check_seq #(
  parameter int unsigned TIMEOUT_CYCLES     = 4096,
  parameter int unsigned CNT_W              = $clog2(TIMEOUT_CYCLES + 1),
  parameter int unsigned ABR_MEM_ADDR_WIDTH = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          zeroize,
  input  logic                          start,
  input  logic [ABR_MEM_ADDR_WIDTH-1:0] z_base_addr,
  input  logic [ABR_MEM_ADDR_WIDTH-1:0] r0_base_addr,
  input  logic [ABR_MEM_ADDR_WIDTH-1:0] ct0_base_addr,
  output logic                          norm_check_enable,
  output logic [1:0]                    mode,
  output logic [ABR_MEM_ADDR_WIDTH-1:0] mem_base_addr,
  input  logic                          nc_invalid,
  input  logic                          nc_done,
  input  logic                          nc_ready,
  output logic                          busy,
  output logic                          seq_done,
  output logic                          reject,
  output logic [2:0]                    reject_cause,
  output logic                          engine_err
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_DONE  = 3'd2,
    S_WAIT_READY = 3'd3,
    S_FINISH     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_Z   = 2'd0,
    MODE_R0  = 2'd1,
    MODE_CT0 = 2'd2
  } chk_norm_mode_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_t                        state_q, state_d;
  logic [1:0]                    idx_q, idx_d;
  chk_norm_mode_t                mode_q, mode_d;
  logic [ABR_MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]              wd_q, wd_d;
  logic [2:0]                    cause_q, cause_d;
  logic                          err_q, err_d;
  logic                          reject_q, reject_d;
  logic                          load_sel;

  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      mode_q   <= MODE_Z;
      addr_q   <= '0;
      wd_q     <= '0;
      cause_q  <= '0;
      err_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      cause_q  <= cause_d;
      err_q    <= err_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    cause_d  = cause_q;
    err_d    = err_q;
    reject_d = reject_q;
    load_sel = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cause_d  = '0;
          err_d    = 1'b0;
          reject_d = 1'b0;
          idx_d    = '0;
          load_sel = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        wd_d = wd_q + CNT_W'(1);
        // done has priority over a watchdog expiring in the same cycle
        if (nc_done) begin
          cause_d[idx_q] = nc_invalid;
          state_d        = S_WAIT_READY;
        end else if (wd_d == TIMEOUT_CNT) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_WAIT_READY: begin
        if (nc_ready) begin
`ifdef NORM_CHECK_SEQ_EARLY_ABORT_EN
          if (idx_q == 2'd2 || cause_q[idx_q]) begin
`else
          if (idx_q == 2'd2) begin
`endif
            state_d = S_FINISH;
          end else begin
            idx_d    = idx_q + 2'd1;
            load_sel = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // mode/address are loaded on the edge into ISSUE and then held through
    // WAIT_READY, because the engine uses them combinationally.
    if (load_sel) begin
      case (idx_d)
        2'd0:    begin mode_d = MODE_Z;   addr_d = z_base_addr;   end
        2'd1:    begin mode_d = MODE_R0;  addr_d = r0_base_addr;  end
        default: begin mode_d = MODE_CT0; addr_d = ct0_base_addr; end
      endcase
    end

    // verdict is registered on the edge into FINISH so it is valid with seq_done
    if (state_d == S_FINISH && state_q != S_FINISH) begin
      reject_d = (|cause_d) | err_d;
    end
  end

  assign norm_check_enable = (state_q == S_ISSUE);
  assign seq_done          = (state_q == S_FINISH);
  assign busy              = (state_q != S_IDLE);
  assign mode              = mode_q;
  assign mem_base_addr     = addr_q;
  assign reject            = reject_q;
  assign reject_cause      = cause_q;
  assign engine_err        = err_q;

endmodule

// File: tb/tb_norm_check_seq.sv
// Scoreboard bench for norm_check_seq. The main instance uses the default
// watchdog. A second instance, with a 16-cycle watchdog, is used only by the
// timeout scenario. The engine model in run_engine answers the enables of the
// selected instance.
module tb_norm_check_seq;
  localparam int unsigned AW = 15;

  typedef struct {
    logic [1:0]    mode;
    logic [AW-1:0] addr;
  } en_t;

  typedef struct {
    logic       rej;
    logic [2:0] cause;
    logic       err;
    int         lat;
    int         n_en;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset, zeroize, start, nc_invalid, nc_done, nc_ready;
  logic [AW-1:0] z_base, r0_base, ct0_base;

  logic          en_a, busy_a, sd_a, rej_a, err_a;
  logic [1:0]    mode_a;
  logic [AW-1:0] addr_a;
  logic [2:0]    cause_a;
  logic          en_b, busy_b, sd_b, rej_b, err_b;
  logic [1:0]    mode_b;
  logic [AW-1:0] addr_b;
  logic [2:0]    cause_b;

  logic          sel_b;
  logic          s_en, s_busy, s_sd, s_rej, s_err;
  logic [1:0]    s_mode;
  logic [AW-1:0] s_addr;
  logic [2:0]    s_cause;

  assign s_en    = sel_b ? en_b    : en_a;
  assign s_busy  = sel_b ? busy_b  : busy_a;
  assign s_sd    = sel_b ? sd_b    : sd_a;
  assign s_rej   = sel_b ? rej_b   : rej_a;
  assign s_err   = sel_b ? err_b   : err_a;
  assign s_mode  = sel_b ? mode_b  : mode_a;
  assign s_addr  = sel_b ? addr_b  : addr_a;
  assign s_cause = sel_b ? cause_b : cause_a;

  norm_check_seq #(.TIMEOUT_CYCLES(4096), .ABR_MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .zeroize(zeroize), .start(start),
    .z_base_addr(z_base), .r0_base_addr(r0_base), .ct0_base_addr(ct0_base),
    .norm_check_enable(en_a), .mode(mode_a), .mem_base_addr(addr_a),
    .nc_invalid(nc_invalid), .nc_done(nc_done), .nc_ready(nc_ready),
    .busy(busy_a), .seq_done(sd_a), .reject(rej_a),
    .reject_cause(cause_a), .engine_err(err_a)
  );

  norm_check_seq #(.TIMEOUT_CYCLES(16), .ABR_MEM_ADDR_WIDTH(AW)) dut_wd (
    .clk(clk), .reset(reset), .zeroize(zeroize), .start(start),
    .z_base_addr(z_base), .r0_base_addr(r0_base), .ct0_base_addr(ct0_base),
    .norm_check_enable(en_b), .mode(mode_b), .mem_base_addr(addr_b),
    .nc_invalid(nc_invalid), .nc_done(nc_done), .nc_ready(nc_ready),
    .busy(busy_b), .seq_done(sd_b), .reject(rej_b),
    .reject_cause(cause_b), .engine_err(err_b)
  );

  int   checks = 0;
  int   errors = 0;
  en_t  en_q[$];
  res_t res_q[$];

  // expected enables and verdict for a sequence whose checks report inv
  task automatic push_seq(input logic [2:0] inv, input int d);
    int   n;
    en_t  e;
    res_t r;
    n = 3;
`ifdef NORM_CHECK_SEQ_EARLY_ABORT_EN
    if (inv[0]) n = 1;
    else if (inv[1]) n = 2;
`endif
    r.cause = 3'b000;
    for (int k = 0; k < n; k++) begin
      e.mode = 2'(k);
      e.addr = (k == 0) ? z_base : ((k == 1) ? r0_base : ct0_base);
      en_q.push_back(e);
      r.cause[k] = inv[k];
    end
    r.err  = 1'b0;
    r.rej  = |r.cause;
    r.lat  = n * (d + 2) + 1;
    r.n_en = n;
    res_q.push_back(r);
  endtask

  task automatic drive_start(output int c0);
    start = 1'b1;
    c0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // engine model plus scoreboard comparison; returns at the seq_done negedge
  task automatic run_engine(input int d, input logic [2:0] inv, input logic [2:0] hang,
                            input bit spur, input int c0, input int budget);
    int   k, t, n_en, rem;
    bit   got, hung;
    en_t  e;
    res_t r;
    k = 0; t = 0; n_en = 0; got = 1'b0;
    while (!got && t < budget) begin
      if (s_sd) begin
        got = 1'b1;
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL verdict_unexpected got seq_done at cycle %0d want none", cyc - c0);
        end else begin
          r = res_q.pop_front();
          if (s_rej !== r.rej) begin
            errors++; $display("FAIL reject got %0b want %0b", s_rej, r.rej);
          end
          checks++;
          if (s_cause !== r.cause) begin
            errors++; $display("FAIL reject_cause got %03b want %03b", s_cause, r.cause);
          end
          checks++;
          if (s_err !== r.err) begin
            errors++; $display("FAIL engine_err got %0b want %0b", s_err, r.err);
          end
          checks++;
          if (cyc - c0 != r.lat) begin
            errors++; $display("FAIL latency got %0d want %0d", cyc - c0, r.lat);
          end
          checks++;
          if (n_en != r.n_en) begin
            errors++; $display("FAIL enable_count got %0d want %0d", n_en, r.n_en);
          end
          checks++;
          if (s_busy !== 1'b1) begin
            errors++; $display("FAIL busy_in_finish got %0b want 1", s_busy);
          end
        end
      end else if (s_en) begin
        n_en++;
        checks++;
        if (en_q.size() == 0) begin
          errors++;
          $display("FAIL extra_enable got enable #%0d want none", n_en);
        end else begin
          e = en_q.pop_front();
          if (s_mode !== e.mode) begin
            errors++; $display("FAIL mode got %0d want %0d", s_mode, e.mode);
          end
          checks++;
          if (s_addr !== e.addr) begin
            errors++; $display("FAIL mem_base_addr got %0h want %0h", s_addr, e.addr);
          end
        end
        rem = d;
        if (spur && k == 0) begin
          // out-of-protocol done and a repeated start during ISSUE
          nc_done = 1'b1; nc_invalid = 1'b1; start = 1'b1;
          @(negedge clk);
          nc_done = 1'b0; nc_invalid = 1'b0; start = 1'b0;
          rem = d - 1;
          t++;
        end
        hung = (k > 2) ? 1'b1 : hang[k];
        if (!hung) begin
          repeat (rem) @(negedge clk);
          nc_done = 1'b1; nc_invalid = inv[k];
          @(negedge clk);
          nc_done = 1'b0; nc_invalid = 1'b0; nc_ready = 1'b1;
          @(negedge clk);
          nc_ready = 1'b0;
          t += rem + 2;
        end else begin
          @(negedge clk);
          t++;
        end
        k++;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL seq_done_timeout got no seq_done within %0d cycles want one", budget);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; zeroize = 1'b0; start = 1'b0;
    nc_invalid = 1'b0; nc_done = 1'b0; nc_ready = 1'b0; sel_b = 1'b0;
    z_base = 15'h0123; r0_base = 15'h0456; ct0_base = 15'h0789;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, sd_a, en_a} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %03b want 000", {busy_a, sd_a, en_a});
    end
    checks++;
    if ({rej_a, cause_a, err_a} !== 5'b0) begin
      errors++; $display("FAIL reset_verdict got %05b want 00000", {rej_a, cause_a, err_a});
    end
    checks++;
    if (mode_a !== 2'd0 || addr_a !== '0) begin
      errors++; $display("FAIL reset_mode_addr got %0d/%0h want 0/0", mode_a, addr_a);
    end
  endtask

  task automatic test_all_valid;
    int c0;
    push_seq(3'b000, 20);
    drive_start(c0);
    run_engine(20, 3'b000, 3'b000, 1'b0, c0, 200);
    @(negedge clk);
    checks++;
    if (sd_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL post_finish got sd=%0b busy=%0b want 0 0", sd_a, busy_a);
    end
  endtask

  task automatic test_r0_invalid;
    int c0;
    push_seq(3'b010, 20);
    drive_start(c0);
    run_engine(20, 3'b010, 3'b000, 1'b0, c0, 200);
    repeat (4) @(negedge clk);
    checks++;
    if (rej_a !== 1'b1 || cause_a !== 3'b010) begin
      errors++; $display("FAIL verdict_hold got %0b/%03b want 1/010", rej_a, cause_a);
    end
  endtask

  task automatic test_timeout;
    int   c0;
    en_t  e;
    res_t r;
    zeroize = 1'b1; @(negedge clk); zeroize = 1'b0;
    sel_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.mode = 2'(k);
      e.addr = (k == 0) ? z_base : ((k == 1) ? r0_base : ct0_base);
      en_q.push_back(e);
    end
    r.rej = 1'b1; r.cause = 3'b000; r.err = 1'b1; r.n_en = 3;
    r.lat = 1 + 2 * (5 + 2) + 1 + 16;
    res_q.push_back(r);
    drive_start(c0);
    run_engine(5, 3'b000, 3'b100, 1'b0, c0, 100);
    zeroize = 1'b1; @(negedge clk); zeroize = 1'b0;
    sel_b = 1'b0;
  endtask

  task automatic test_zeroize;
    int  c0, n_sd;
    bit  seen;
    seen = 1'b0;
    drive_start(c0);
    for (int i = 0; i < 5 && !seen; i++) begin
      if (en_a) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL zeroize_enable got none want enable");
    end
    repeat (3) @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    checks++;
    if ({busy_a, sd_a, en_a, rej_a, cause_a, err_a} !== 8'b0) begin
      errors++;
      $display("FAIL zeroize_outputs got %08b want 00000000", {busy_a, sd_a, en_a, rej_a, cause_a, err_a});
    end
    checks++;
    if (mode_a !== 2'd0 || addr_a !== '0) begin
      errors++; $display("FAIL zeroize_mode_addr got %0d/%0h want 0/0", mode_a, addr_a);
    end
    n_sd = 0;
    for (int i = 0; i < 40; i++) begin
      if (sd_a) n_sd++;
      @(negedge clk);
    end
    checks++;
    if (n_sd != 0) begin
      errors++; $display("FAIL zeroize_seq_done got %0d pulses want 0", n_sd);
    end
    push_seq(3'b101, 20);
    drive_start(c0);
    run_engine(20, 3'b101, 3'b000, 1'b0, c0, 200);
    @(negedge clk);
  endtask

  task automatic test_busy_start;
    int c0;
    push_seq(3'b100, 20);
    drive_start(c0);
    run_engine(20, 3'b100, 3'b000, 1'b1, c0, 200);
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL busy_after_ignored_start got %0b want 0", busy_a);
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    push_seq(3'b011, 20);
    drive_start(c0);
    run_engine(20, 3'b011, 3'b000, 1'b0, c0, 200);
    @(negedge clk);
    z_base = 15'h1111; r0_base = 15'h2222; ct0_base = 15'h3333;
    push_seq(3'b100, 20);
    drive_start(c0);
    checks++;
    if (cause_a !== 3'b000 || rej_a !== 1'b0) begin
      errors++; $display("FAIL b2b_clear got %03b/%0b want 000/0", cause_a, rej_a);
    end
    run_engine(20, 3'b100, 3'b000, 1'b0, c0, 200);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_all_valid();
    test_r0_invalid();
    test_timeout();
    test_zeroize();
    test_busy_start();
    test_back_to_back();
    checks++;
    if (en_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d left want 0/0", en_q.size(), res_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
